// File: rtl/transducer_fire_controller_pkg.sv
// Shared types and defaults for the transducer fire controller.
// Holds the FSM state encoding and counter width.
package transducer_fire_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MARK,
        ST_FIRE,
        ST_DONE
    } fsm_state_e;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_MARK_CYCLES = 4;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/transducer_fire_controller_fire_phase_timer.sv
// Saturating FIRE-phase cycle counter with timeout compare.
// expire looks at the post-increment value so the limit cycle itself exits.
module fire_phase_timer
    import transducer_fire_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d, count_inc;

    always_comb begin
        count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_inc;
        end
        expire = run && (limit != '0) && (count_inc == limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/transducer_fire_controller.sv
// Sequences channel reset, arm and fire strobes for a transducer array.
// All outputs come straight from flops.
module transducer_fire_controller
    import transducer_fire_controller_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int MARK_CYCLES = DEF_MARK_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fireReq,
    input  logic              abort,
    input  logic [NUM_CH-1:0] chanEnable,
    input  logic [CNT_W-1:0]  timeoutCycles,
    input  logic [NUM_CH-1:0] fireComplete,
    input  logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] chanActive,
    output logic              chanRst,
    output logic              onYourMark,
    output logic              GOGOGO_EXCLAMATION,
    output logic              busy,
    output logic              done,
    output logic              timedOut,
    output logic              aborted,
    output logic [NUM_CH-1:0] warnFlags,
    output logic [CNT_W-1:0]  fireCycles
);

    localparam int MW = $clog2(MARK_CYCLES);
    localparam logic [MW-1:0] MARK_LAST = MW'(MARK_CYCLES - 1);

    fsm_state_e        state_q, state_d;
    logic [MW-1:0]     mark_cnt_q, mark_cnt_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] warn_q, warn_d, warn_hit;
    logic              chan_rst_q, chan_rst_d;
    logic              mark_q, mark_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timed_q, timed_d;
    logic              aborted_q, aborted_d;
    logic              clear, expire, complete;

    fire_phase_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .run    (state_q == ST_FIRE),
        .limit  (timeoutCycles),
        .count  (fireCycles),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        active_d   = active_q;
        warn_d     = warn_q;
        timed_d    = timed_q;
        aborted_d  = aborted_q;
        chan_rst_d = 1'b0;
        mark_d     = 1'b0;
        go_d       = 1'b0;
        done_d     = 1'b0;
        clear      = 1'b0;
        warn_hit   = warning & active_q;
        complete   = (fireComplete & active_q) == active_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fireReq) begin
                    clear     = 1'b1;
                    warn_d    = '0;
                    timed_d   = 1'b0;
                    aborted_d = 1'b0;
                    if (chanEnable != '0) begin
                        active_d   = chanEnable;
                        chan_rst_d = 1'b1;
                        state_d    = ST_ARM;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ARM: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    mark_cnt_d = '0;
                    mark_d     = 1'b1;
                    state_d    = ST_MARK;
                end
            end
            ST_MARK: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (mark_cnt_q == MARK_LAST) begin
                    mark_d  = 1'b1;
                    go_d    = 1'b1;
                    state_d = ST_FIRE;
                end else begin
                    mark_cnt_d = mark_cnt_q + MW'(1);
                    mark_d     = 1'b1;
                end
            end
            ST_FIRE: begin
                // Completion outranks timeout; warnings are captured regardless.
                if (abort || complete || (warn_hit != '0) || expire) begin
                    warn_d    = warn_q | warn_hit;
                    aborted_d = abort;
                    timed_d   = !abort && !complete && expire;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    mark_d = 1'b1;
                    go_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mark_cnt_q <= '0;
            active_q   <= '0;
            warn_q     <= '0;
            timed_q    <= 1'b0;
            aborted_q  <= 1'b0;
            chan_rst_q <= 1'b0;
            mark_q     <= 1'b0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mark_cnt_q <= mark_cnt_d;
            active_q   <= active_d;
            warn_q     <= warn_d;
            timed_q    <= timed_d;
            aborted_q  <= aborted_d;
            chan_rst_q <= chan_rst_d;
            mark_q     <= mark_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign chanActive         = active_q;
    assign chanRst            = chan_rst_q;
    assign onYourMark         = mark_q;
    assign GOGOGO_EXCLAMATION = go_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign timedOut           = timed_q;
    assign aborted            = aborted_q;
    assign warnFlags          = warn_q;

endmodule

// File: tb/tb_transducer_fire_controller.sv
// Directed bench for transducer_fire_controller.
// Vector table for full sequences plus hand-written corner cases.
module tb_transducer_fire_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fireReq, abort;
    logic [7:0]  chanEnable, fireComplete, warning;
    logic [15:0] timeoutCycles;
    logic [7:0]  chanActive, warnFlags;
    logic        chanRst, onYourMark, GOGOGO_EXCLAMATION;
    logic        busy, done, timedOut, aborted;
    logic [15:0] fireCycles;

    int checks = 0;
    int passes = 0;

    transducer_fire_controller #(.NUM_CH(8), .MARK_CYCLES(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fireReq            (fireReq),
        .abort              (abort),
        .chanEnable         (chanEnable),
        .timeoutCycles      (timeoutCycles),
        .fireComplete       (fireComplete),
        .warning            (warning),
        .chanActive         (chanActive),
        .chanRst            (chanRst),
        .onYourMark         (onYourMark),
        .GOGOGO_EXCLAMATION (GOGOGO_EXCLAMATION),
        .busy               (busy),
        .done               (done),
        .timedOut           (timedOut),
        .aborted            (aborted),
        .warnFlags          (warnFlags),
        .fireCycles         (fireCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [15:0] to;
        int          comp_at;
        logic [7:0]  warn;
        int          warn_at;
        int          abort_t;
        int          exp_t;
        logic [15:0] exp_fc;
        logic        exp_to;
        logic        exp_ab;
        logic [7:0]  exp_warn;
        int          exp_marks;
        logic        exp_go;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fireReq = 0; abort = 0; fireComplete = 0; warning = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int t;
        int marks;
        bit seen, go_seen, bad;
        fireReq = 1; chanEnable = v.en; timeoutCycles = v.to;
        abort = 0; fireComplete = 0; warning = 0;
        tick;
        fireReq = 0;
        t = 1;
        chk($sformatf("v%0d_arm_rst", idx), chanRst, 1);
        chk($sformatf("v%0d_clr", idx), {timedOut, aborted, warnFlags, fireCycles}, 0);
        chk($sformatf("v%0d_active", idx), chanActive, v.en);
        marks = 0; seen = 0; go_seen = 0; bad = 0;
        while (!seen && t < 300) begin
            fireComplete = (v.comp_at != 0 && t == 5 + v.comp_at) ? v.en : 8'h00;
            warning = (v.warn_at != 0 && t == 5 + v.warn_at) ? v.warn : 8'h00;
            abort = (t == v.abort_t);
            tick;
            t++;
            if (onYourMark && !GOGOGO_EXCLAMATION) marks++;
            if (GOGOGO_EXCLAMATION) go_seen = 1;
            if (GOGOGO_EXCLAMATION && !onYourMark) bad = 1;
            if (chanRst) bad = 1;
            if (done) seen = 1;
        end
        idle_inputs();
        chk($sformatf("v%0d_done_seen", idx), seen, 1);
        chk($sformatf("v%0d_done_t", idx), t, v.exp_t);
        chk($sformatf("v%0d_fc", idx), fireCycles, v.exp_fc);
        chk($sformatf("v%0d_timedout", idx), timedOut, v.exp_to);
        chk($sformatf("v%0d_aborted", idx), aborted, v.exp_ab);
        chk($sformatf("v%0d_warn", idx), warnFlags, v.exp_warn);
        chk($sformatf("v%0d_marks", idx), marks, v.exp_marks);
        chk($sformatf("v%0d_go", idx), go_seen, v.exp_go);
        chk($sformatf("v%0d_strobe_rules", idx), bad, 0);
        chk($sformatf("v%0d_done_strobes", idx), {onYourMark, GOGOGO_EXCLAMATION, busy}, 3'b001);
        tick;
        chk($sformatf("v%0d_after", idx), {done, busy}, 0);
        chk($sformatf("v%0d_hold_active", idx), chanActive, v.en);
    endtask

    initial begin
        vecs[0] = '{8'h0F, 16'd100, 20, 8'h00, 0, 0, 26, 16'd20, 0, 0, 8'h00, 4, 1};
        vecs[1] = '{8'h01, 16'd10,  0,  8'h00, 0, 0, 16, 16'd10, 1, 0, 8'h00, 4, 1};
        vecs[2] = '{8'h06, 16'd0,   0,  8'h04, 5, 0, 11, 16'd5,  0, 0, 8'h04, 4, 1};
        vecs[3] = '{8'h06, 16'd0,   7,  8'h81, 3, 0, 13, 16'd7,  0, 0, 8'h00, 4, 1};
        vecs[4] = '{8'h0F, 16'd0,   0,  8'h00, 0, 3, 4,  16'd0,  0, 1, 8'h00, 2, 0};
        vecs[5] = '{8'h03, 16'd8,   8,  8'h00, 0, 0, 14, 16'd8,  0, 0, 8'h00, 4, 1};
        vecs[6] = '{8'h0F, 16'd0,   6,  8'h02, 6, 0, 12, 16'd6,  0, 0, 8'h02, 4, 1};
        vecs[7] = '{8'hFF, 16'd0,   0,  8'h00, 0, 8, 9,  16'd3,  0, 1, 8'h00, 4, 1};
        vecs[8] = '{8'h80, 16'd0,   12, 8'h00, 0, 0, 18, 16'd12, 0, 0, 8'h00, 4, 1};
        vecs[9] = '{8'h3C, 16'd5,   0,  8'h00, 0, 1, 2,  16'd0,  0, 1, 8'h00, 0, 0};

        rst_n = 0; idle_inputs(); chanEnable = 0; timeoutCycles = 0;
        #12;
        chk("reset_outputs", {chanActive, chanRst, onYourMark, GOGOGO_EXCLAMATION,
            busy, done, timedOut, aborted, warnFlags, fireCycles}, 0);
        @(negedge clk);
        rst_n = 1;
        tick;
        chk("post_reset_idle", {busy, done}, 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // chanEnable == 0: straight to DONE, status cleared, no strobes
        fireReq = 1; chanEnable = 8'h00; timeoutCycles = 16'd3;
        tick;
        fireReq = 0;
        chk("zero_en_done", {done, busy}, 2'b11);
        chk("zero_en_strobes", {chanRst, onYourMark, GOGOGO_EXCLAMATION}, 0);
        chk("zero_en_status", {timedOut, aborted, warnFlags, fireCycles}, 0);
        tick;
        chk("zero_en_after", {done, busy}, 0);

        // fireReq while busy is ignored and not queued
        fireReq = 1; chanEnable = 8'h01; timeoutCycles = 0;
        tick;
        fireReq = 0;
        tick;
        fireReq = 1; chanEnable = 8'hFF;
        tick;
        fireReq = 0;
        chk("busy_req_active", chanActive, 8'h01);
        tick; tick; tick;
        chk("busy_req_fire", {onYourMark, GOGOGO_EXCLAMATION}, 2'b11);
        fireComplete = 8'h01;
        tick;
        fireComplete = 0;
        chk("busy_req_done", {done, chanActive}, {1'b1, 8'h01});
        tick;
        chk("busy_req_idle1", busy, 0);
        tick;
        chk("busy_req_idle2", {busy, chanRst}, 0);

        // asynchronous reset in FIRE drops everything immediately
        fireReq = 1; chanEnable = 8'h0F; timeoutCycles = 0;
        tick;
        fireReq = 0;
        for (int k = 0; k < 7; k++) tick;
        chk("rst_fire_pre", {onYourMark, GOGOGO_EXCLAMATION, fireCycles}, {2'b11, 16'd2});
        #2 rst_n = 0;
        #1;
        chk("rst_fire_now", {chanActive, chanRst, onYourMark, GOGOGO_EXCLAMATION,
            busy, done, timedOut, aborted, warnFlags, fireCycles}, 0);
        tick;
        rst_n = 1;
        tick;
        chk("rst_fire_nodone", {done, busy, onYourMark}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/transducer_fire_controller.md
TRANSDUCER_FIRE_CONTROLLER -- requirements
Module: transducer_fire_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of transducer channels driven.
REQ-002 Parameter MARK_CYCLES, default 4, cycles onYourMark is held before GOGOGO_EXCLAMATION rises; minimum 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fireReq  input  1  request one fire sequence; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sequence in progress.
REQ-007 chanEnable  input  NUM_CH  channels to fire; sampled on accept.
REQ-008 timeoutCycles  input  16  FIRE-phase limit in cycles; 0 disables the timeout.
REQ-009 fireComplete  input  NUM_CH  per-channel completion from the channels.
REQ-010 warning  input  NUM_CH  per-channel over-drive warning from the channels.
REQ-011 chanActive  output  NUM_CH  isActive mask to the channels.
REQ-012 chanRst  output  1  synchronous active-high reset to all channels.
REQ-013 onYourMark  output  1  arm strobe to all channels.
REQ-014 GOGOGO_EXCLAMATION  output  1  fire strobe to all channels.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at sequence end.
REQ-017 timedOut, aborted  output  1 each  sticky status; cleared on next accept.
REQ-018 warnFlags  output  NUM_CH  sticky per-channel warning capture; cleared on next accept.
REQ-019 fireCycles  output  16  FIRE-phase cycle count, saturating at 0xFFFF; cleared on next accept.

Function
REQ-020 FSM states: IDLE, ARM, MARK, FIRE, DONE.
REQ-021 IDLE: fireReq=1 with chanEnable!=0 -> latch chanActive<=chanEnable, clear status, go to ARM.
REQ-022 IDLE: fireReq=1 with chanEnable==0 -> go to DONE directly; status stays zero.
REQ-023 ARM: assert chanRst for exactly 1 cycle, then go to MARK.
REQ-024 MARK: onYourMark=1, GOGOGO_EXCLAMATION=0 for exactly MARK_CYCLES cycles, then go to FIRE.
REQ-025 FIRE: onYourMark=1, GOGOGO_EXCLAMATION=1; fireCycles increments each cycle.
REQ-026 FIRE exit, completion: (fireComplete & chanActive)==chanActive -> DONE.
REQ-027 FIRE exit, warning: any (warning & chanActive) bit -> OR it into warnFlags and go to DONE.
REQ-028 FIRE exit, timeout: timeoutCycles!=0 and fireCycles reaches timeoutCycles -> timedOut=1, DONE.
REQ-029 Same-cycle completion and timeout: completion wins; timedOut stays 0.
REQ-030 Same-cycle completion and warning: warnFlags is captured; DONE is entered once.
REQ-031 abort in ARM, MARK or FIRE -> aborted=1; next state DONE.
REQ-032 abort in IDLE or DONE has no effect.
REQ-033 DONE: onYourMark=0, GOGOGO_EXCLAMATION=0, done=1 for 1 cycle, then go to IDLE.
REQ-034 chanActive holds its value after DONE until the next accept.
REQ-035 fireReq outside IDLE is ignored; requests are not queued.
REQ-036 Strobes are registered outputs. GOGOGO_EXCLAMATION is never high while onYourMark is low.

Reset
REQ-037 While rst_n=0: state=IDLE; chanActive=0; chanRst=0; onYourMark=0; GOGOGO_EXCLAMATION=0; busy=0; done=0; timedOut=0; aborted=0; warnFlags=0; fireCycles=0.
REQ-038 A mid-sequence reset drops both strobes immediately (asynchronously); no done pulse is issued.

Structure
REQ-039 A shared package holds the FSM state enumeration, the default NUM_CH, the default MARK_CYCLES and the 16-bit counter width.
REQ-040 One sub-module, fire_phase_timer, holds the saturating fireCycles counter and the timeout comparator.

Verification
REQ-041 Normal fire: NUM_CH=8, chanEnable=0x0F, timeoutCycles=100, fireComplete[3:0] all high 20 cycles into FIRE -> required sequence:
  - chanRst for 1 cycle;
  - 4 MARK cycles;
  - done pulse, fireCycles=20, no error flags.
REQ-042 Timeout: chanEnable=0x01, timeoutCycles=10, fireComplete held 0 -> timedOut=1, fireCycles=10, done after 10 FIRE cycles.
REQ-043 Warning: chanEnable=0x06, warning[2]=1 in FIRE cycle 5 -> warnFlags=0x04, done on the next cycle, strobes low.
REQ-044 Abort in MARK cycle 2 -> aborted=1, GOGOGO_EXCLAMATION never rises, done on the next cycle.
REQ-045 Boundaries:
  - completion and timeout in the same cycle -> timedOut=0;
  - chanEnable=0 -> done 1 cycle after request, no strobes;
  - fireReq while busy -> ignored;
  - rst_n low in FIRE -> all outputs 0 immediately.
